prog_seq_ctr: RTL and testbench

- Parametrised next-generation program counter and instruction-fetch sequencer for the CSE141L processor.
- Supports N back-to-back programs with parameterised start addresses, selected by Start pulses from the test bench.
- Supports four branch flavours (program-base-relative, absolute, PC-relative signed, call/return) and a small hardware return-address stack.
- Sits between the control decoder/ALU flag and instruction memory; ProgCtr drives the IM address directly.

---
 rtl/prog_seq_ctr_pkg.sv | 36 +++
 rtl/prog_seq_ctr_if.sv | 34 +++
 rtl/prog_seq_ctr_ret_stack.sv | 47 ++++
 rtl/prog_seq_ctr.sv | 149 ++++++++++++++
 tb/tb_prog_seq_ctr.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_seq_ctr_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package prog_seq_pkg;

  // Branch opcodes carried on BrOp; 6 and 7 are reserved and act like BR_NONE.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JB   = 3'd1,
    BR_JA   = 3'd2,
    BR_JR   = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5,
    BR_RSV6 = 3'd6,
    BR_RSV7 = 3'd7
  } br_op_e;

  // Sequencer run state: waiting for the first launch, running, or finished.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int DEF_A     = 10;
  localparam int DEF_NPROG = 3;

  // Program start addresses; entry 0 belongs to program 1.
  localparam logic [DEF_NPROG-1:0][DEF_A-1:0] DEF_PROG_BASE = {10'd500, 10'd200, 10'd0};

  // Sign-extend the low tw bits of t to 32 bits; callers keep the low A bits.
  function automatic logic [31:0] sext_target(input logic [31:0] t, input int tw);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << tw;
    return t[tw-1] ? (t | hi_mask) : (t & ~hi_mask);
  endfunction

endpackage

// File: rtl/prog_seq_ctr_if.sv
// Control/fetch bundle between the decoder side and the sequencer.
interface prog_seq_ctr_if
  import prog_seq_pkg::*;
#(
  parameter int A      = 10,
  parameter int TW     = 8,
  parameter int SDEPTH = 4
);
  localparam int DW = $clog2(SDEPTH) + 1;

  logic          Start;
  logic          Stall;
  br_op_e        BrOp;
  logic          ALU_flag;
  logic [TW-1:0] Target;
  logic [A-1:0]  ProgCtr;
  logic [2:0]    ProgIdx;
  logic          Running;
  logic          AllDone;
  logic          StackOvf;
  logic          StackUnf;
  logic [DW-1:0] StackDepth;

  modport master (
    output Start, Stall, BrOp, ALU_flag, Target,
    input  ProgCtr, ProgIdx, Running, AllDone, StackOvf, StackUnf, StackDepth
  );

  modport slave (
    input  Start, Stall, BrOp, ALU_flag, Target,
    output ProgCtr, ProgIdx, Running, AllDone, StackOvf, StackUnf, StackDepth
  );

endinterface

// File: rtl/prog_seq_ctr_ret_stack.sv
// Small return-address LIFO. Top of stack is readable combinationally so a
// RET can load it in the same cycle it pops.
module ret_stack #(
  parameter int A      = 10,
  parameter int SDEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [A-1:0]               din,
  output logic [A-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(SDEPTH):0]    depth
);
  localparam int PW = $clog2(SDEPTH);
  localparam int DW = PW + 1;

  logic [A-1:0]  mem [SDEPTH];
  logic [DW-1:0] depth_reg;
  logic [PW-1:0] top_idx;

  assign full    = (depth_reg == DW'(SDEPTH));
  assign empty   = (depth_reg == '0);
  assign depth   = depth_reg;
  // Wraps to the last slot when empty; the parent never pops an empty stack.
  assign top_idx = depth_reg[PW-1:0] - 1'b1;
  assign dout    = mem[top_idx];

  // Storage and occupancy; clear wins over push/pop, overflowing pushes are dropped.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      depth_reg <= '0;
      for (int i = 0; i < SDEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      mem[depth_reg[PW-1:0]] <= din;
      depth_reg              <= depth_reg + 1'b1;
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - 1'b1;
    end
  end

endmodule

// File: rtl/prog_seq_ctr.sv
// Program counter and instruction-fetch sequencer: launches a series of
// programs on Start pulses and applies branch/call/return actions to the PC.
module prog_seq_ctr
  import prog_seq_pkg::*;
#(
  parameter int                        A         = DEF_A,
  parameter int                        TW        = 8,
  parameter int                        NPROG     = DEF_NPROG,
  parameter logic [NPROG-1:0][A-1:0]   PROG_BASE = DEF_PROG_BASE,
  parameter int                        SDEPTH    = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  prog_seq_ctr_if.slave  bus
);
  localparam int DW = $clog2(SDEPTH) + 1;
  // Program index is kept one bit wider than the output so NPROG+1 fits even for NPROG=8.
  localparam int              IW       = 4;
  localparam logic [IW-1:0]   IDX_DONE = IW'(NPROG + 1);

  seq_state_e    state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [A-1:0]  pc_reg, pc_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;
  logic          start_r;

  logic          start_rise, start_fall, idx_valid, launch, advance;
  logic [A-1:0]  base, pc_inc, tgt_zx, tgt_sx;
  logic          stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [A-1:0]  stk_dout;
  logic [DW-1:0] stk_depth;

  assign start_rise = bus.Start && !start_r;
  assign start_fall = !bus.Start && start_r;
  assign idx_valid  = (idx_reg != '0) && (idx_reg <= IW'(NPROG));
  assign launch     = start_fall && idx_valid && (state_reg != ST_DONE);
  assign advance    = (state_reg == ST_RUN) && !bus.Stall;
  assign pc_inc     = pc_reg + 1'b1;
  assign tgt_zx     = A'(bus.Target);
  assign tgt_sx     = A'(sext_target(32'(bus.Target), TW));

  // Start address of the program currently selected by idx_reg.
  always_comb begin
    base = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (idx_reg == IW'(i + 1)) base = PROG_BASE[i];
    end
  end

  // Run-state and program-index register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Start falling edge launches a program; the rising edge past the last program finishes.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (launch) state_next = ST_RUN;
    if (start_rise) begin
      if (idx_reg != IDX_DONE) idx_next = idx_reg + 1'b1;
      if (idx_next == IDX_DONE) state_next = ST_DONE;
    end
  end

  // Next PC, stack requests and sticky flags; launch beats stall and any branch.
  always_comb begin
    pc_next  = pc_reg;
    ovf_next = ovf_reg;
    unf_next = unf_reg;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    if (launch) begin
      pc_next  = base;
      stk_clr  = 1'b1;
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end else if (advance) begin
      case (bus.BrOp)
        BR_JB:   pc_next = bus.ALU_flag ? (base + tgt_zx) : pc_inc;
        BR_JA:   pc_next = tgt_zx;
        BR_JR:   pc_next = bus.ALU_flag ? (pc_reg + tgt_sx) : pc_inc;
        BR_CALL: begin
          pc_next = base + tgt_zx;
          if (stk_full) ovf_next = 1'b1;
          else          stk_push = 1'b1;
        end
        BR_RET: begin
          if (stk_empty) begin
            pc_next  = pc_inc;
            unf_next = 1'b1;
          end else begin
            pc_next = stk_dout;
            stk_pop = 1'b1;
          end
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  // PC, sticky stack flags and the Start history bit.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
      start_r <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
      start_r <= bus.Start;
    end
  end

  ret_stack #(
    .A      (A),
    .SDEPTH (SDEPTH)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (stk_clr),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (stk_depth)
  );

  assign bus.ProgCtr    = pc_reg;
  assign bus.ProgIdx    = idx_reg[2:0];
  assign bus.Running    = (state_reg == ST_RUN);
  assign bus.AllDone    = (state_reg == ST_DONE);
  assign bus.StackOvf   = ovf_reg;
  assign bus.StackUnf   = unf_reg;
  assign bus.StackDepth = stk_depth;

endmodule

// File: tb/tb_prog_seq_ctr.sv
// Bench for prog_seq_ctr: directed vector table, hand-written async-reset and
// held-Start sequences, then random stimulus against a behavioural model.
module tb_prog_seq_ctr;
  import prog_seq_pkg::*;

  localparam int A      = 10;
  localparam int TW     = 8;
  localparam int NPROG  = 3;
  localparam int SDEPTH = 4;
  localparam int PCMOD  = 1 << A;
  localparam int BASES [NPROG] = '{0, 200, 500};

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  prog_seq_ctr_if #(.A(A), .TW(TW), .SDEPTH(SDEPTH)) bus ();

  prog_seq_ctr #(
    .A         (A),
    .TW        (TW),
    .NPROG     (NPROG),
    .PROG_BASE ({10'd500, 10'd200, 10'd0}),
    .SDEPTH    (SDEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit s; bit st; int op; bit f; int t;
    int pc; int idx; bit run; bit done; bit ovf; bit unf; int depth;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model state
  int m_pc, m_idx;
  bit m_run, m_done, m_ovf, m_unf, m_sprev;
  int m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int idx, input int run,
                         input int done, input int ovf, input int unf, input int depth);
    chk($sformatf("%s.pc", tag),    32'(bus.ProgCtr),    pc);
    chk($sformatf("%s.idx", tag),   32'(bus.ProgIdx),    idx);
    chk($sformatf("%s.run", tag),   32'(bus.Running),    run);
    chk($sformatf("%s.done", tag),  32'(bus.AllDone),    done);
    chk($sformatf("%s.ovf", tag),   32'(bus.StackOvf),   ovf);
    chk($sformatf("%s.unf", tag),   32'(bus.StackUnf),   unf);
    chk($sformatf("%s.depth", tag), 32'(bus.StackDepth), depth);
  endtask

  task automatic drive(input bit s, input bit st, input int op, input bit f, input int t);
    bus.Start    = s;
    bus.Stall    = st;
    bus.BrOp     = br_op_e'(op[2:0]);
    bus.ALU_flag = f;
    bus.Target   = t[TW-1:0];
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add_vec(input bit s, input bit st, input int op, input bit f, input int t,
                         input int pc, input int idx, input bit run, input bit done,
                         input bit ovf, input bit unf, input int depth);
    vec_t r;
    r = '{s, st, op, f, t, pc, idx, run, done, ovf, unf, depth};
    vecs.push_back(r);
  endtask

  function automatic int wrap(input int x);
    return ((x % PCMOD) + PCMOD) % PCMOD;
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_idx = 0; m_run = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_sprev = 0;
    m_stk.delete();
  endfunction

  // One clock edge of the sequencer, written from the behavioural rules.
  function automatic void model_edge(input bit s, input bit st, input int op, input bit f, input int t);
    bit rise, fall;
    int base, off;
    rise = s && !m_sprev;
    fall = !s && m_sprev;
    base = (m_idx >= 1 && m_idx <= NPROG) ? BASES[m_idx-1] : 0;
    off  = (t >= 128) ? t - 256 : t;
    if (fall && !m_done && m_idx >= 1 && m_idx <= NPROG) begin
      m_pc = base; m_run = 1; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_run && !st) begin
      case (op)
        1: m_pc = f ? wrap(base + t) : wrap(m_pc + 1);
        2: m_pc = t;
        3: m_pc = f ? wrap(m_pc + off) : wrap(m_pc + 1);
        4: begin
          if (m_stk.size() < SDEPTH) m_stk.push_back(wrap(m_pc + 1));
          else m_ovf = 1;
          m_pc = wrap(base + t);
        end
        5: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = wrap(m_pc + 1); m_unf = 1; end
        end
        default: m_pc = wrap(m_pc + 1);
      endcase
    end
    if (rise && m_idx < NPROG + 1) begin
      m_idx++;
      if (m_idx == NPROG + 1) begin m_done = 1; m_run = 0; end
    end
    m_sprev = s;
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    Reset = 1'b0;
    model_reset();
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s_rand;
    //                s  st op f  t     pc    idx run done ovf unf depth
    add_vec(1, 0, 0, 0, 0,      0,   1, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      0,   1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      1,   1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      2,   1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      3,   1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 4, 0, 40,     40,  1, 1, 0, 0, 0, 1);
    add_vec(0, 0, 5, 0, 0,      4,   1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 5, 0, 0,      5,   1, 1, 0, 0, 1, 0);
    add_vec(0, 1, 4, 0, 10,     5,   1, 1, 0, 0, 1, 0);
    add_vec(0, 0, 4, 0, 10,     10,  1, 1, 0, 0, 1, 1);
    add_vec(0, 0, 4, 0, 20,     20,  1, 1, 0, 0, 1, 2);
    add_vec(0, 0, 4, 0, 30,     30,  1, 1, 0, 0, 1, 3);
    add_vec(0, 0, 4, 0, 40,     40,  1, 1, 0, 0, 1, 4);
    add_vec(0, 0, 4, 0, 50,     50,  1, 1, 0, 1, 1, 4);
    add_vec(0, 0, 5, 0, 0,      31,  1, 1, 0, 1, 1, 3);
    add_vec(1, 0, 2, 0, 100,    100, 2, 1, 0, 1, 1, 3);
    add_vec(0, 1, 4, 0, 7,      200, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 2, 0, 210,    210, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 5,      205, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 2, 0, 210,    210, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 5,      211, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 1, 8'hFE,  209, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 0, 8'hFE,  210, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 2, 0, 0,      0,   2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 1, 8'hFF,  1023, 2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      0,   2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 6, 1, 77,     1,   2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 7, 1, 99,     2,   2, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 1, 3,      203, 2, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0,      204, 3, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      500, 3, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      501, 3, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0,      502, 4, 0, 1, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      502, 4, 0, 1, 0, 0, 0);
    add_vec(1, 0, 2, 0, 7,      502, 4, 0, 1, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,      502, 4, 0, 1, 0, 0, 0);

    // Reset state, then idle with no Start for 20 cycles
    drive(0, 0, 0, 0, 0);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d.pc", i), 32'(bus.ProgCtr), 0);
      chk($sformatf("idle%0d.run", i), 32'(bus.Running), 0);
      chk($sformatf("idle%0d.idx", i), 32'(bus.ProgIdx), 0);
    end
    $display("idle: 20 cycles without Start");

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].st, vecs[i].op, vecs[i].f, vecs[i].t);
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].idx, vecs[i].run, vecs[i].done,
              vecs[i].ovf, vecs[i].unf, vecs[i].depth);
      $display("vec %0d: start=%0b stall=%0b op=%0d flag=%0b tgt=%0d -> pc=%0d idx=%0d depth=%0d",
               i, vecs[i].s, vecs[i].st, vecs[i].op, vecs[i].f, vecs[i].t,
               bus.ProgCtr, bus.ProgIdx, bus.StackDepth);
    end

    // Start held high for several cycles counts as a single request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
      chk($sformatf("hold%0d.idx", i), 32'(bus.ProgIdx), 1);
      chk($sformatf("hold%0d.run", i), 32'(bus.Running), 0);
    end
    drive(0, 0, 0, 0, 0);
    tick();
    chk_all("hold.launch", 0, 1, 1, 0, 0, 0, 0);
    $display("held start: single launch at pc=%0d", bus.ProgCtr);

    // Run to PC=3, call, then assert reset between clock edges
    for (int i = 1; i <= 3; i++) tick();
    chk("pre_async.pc", 32'(bus.ProgCtr), 3);
    drive(0, 0, 4, 0, 60);
    tick();
    chk_all("pre_async.call", 60, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    $display("async reset: pc=%0d run=%0b depth=%0d", bus.ProgCtr, bus.Running, bus.StackDepth);

    // Random stimulus against the behavioural model
    s_rand = 0;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      s_rand = 0;
      for (int c = 0; c < 250; c++) begin
        bit st, f;
        int op, t;
        if ($urandom_range(0, 24) == 0) s_rand = !s_rand;
        st = ($urandom_range(0, 4) == 0);
        op = $urandom_range(0, 7);
        f  = $urandom_range(0, 1) == 1;
        t  = $urandom_range(0, 255);
        drive(s_rand, st, op, f, t);
        model_edge(s_rand, st, op, f, t);
        tick();
        chk_all($sformatf("rnd%0d.%0d", seg, c), m_pc, m_idx, m_run, m_done,
                m_ovf, m_unf, m_stk.size());
      end
      $display("random segment %0d: pc=%0d idx=%0d done=%0b checks=%0d",
               seg, bus.ProgCtr, bus.ProgIdx, bus.AllDone, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
